// File: rtl/rs_degree_scheduler.sv
// rtl/rs_degree_scheduler.sv - round-robin shared degree evaluator for lambda (A) / omega (B) polynomials
// Optional macro RS_DEGREE_FAST_EN: single-cycle priority-encoder scan instead of the serial top-down scan.
module rs_degree_scheduler #(
  parameter int NCOEF = 20,
  parameter int SYMW  = 6,
  parameter int DEGW  = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  clear,
  input  logic                  req_a,
  input  logic [NCOEF*SYMW-1:0] poly_a,
  input  logic                  req_b,
  input  logic [NCOEF*SYMW-1:0] poly_b,
  output logic                  grant_a,
  output logic                  grant_b,
  output logic                  busy,
  output logic                  done,
  output logic                  done_id,
  output logic [DEGW-1:0]       degree
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  state_t                  state, state_nxt;
  logic                    last_b;
  logic                    tag;
  logic                    pick_a, pick_b;
  logic                    scan_end;
  logic [DEGW-1:0]         found_deg;
  logic [NCOEF*SYMW-1:0]   coef_q;

`ifdef RS_DEGREE_FAST_EN
  always_comb begin
    found_deg = '0;
    for (int i = 0; i < NCOEF; i++) begin
      if (coef_q[i*SYMW +: SYMW] != '0) found_deg = DEGW'(i);
    end
  end
  assign scan_end = 1'b1;
`else
  logic [DEGW-1:0] idx;
  logic [SYMW-1:0] cur;
  assign cur       = coef_q[int'(idx)*SYMW +: SYMW];
  assign found_deg = idx;
  // A zero coefficient at index 0 ends the scan too, reporting degree 0.
  assign scan_end  = (cur != '0) || (idx == '0);
`endif

  // Ties go to whichever requester was not granted last.
  assign pick_a = req_a && (!req_b || last_b);
  assign pick_b = req_b && (!req_a || !last_b);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (!clear && (req_a || req_b)) state_nxt = SCAN;
      SCAN: if (clear)                      state_nxt = IDLE;
            else if (scan_end)              state_nxt = DONE;
      DONE:                                 state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_a = RESET && (state == IDLE) && !clear && pick_a;
    grant_b = RESET && (state == IDLE) && !clear && pick_b;
    busy    = (state != IDLE);
    done    = (state == DONE) && !clear;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      last_b  <= 1'b1;
      tag     <= 1'b0;
      coef_q  <= '0;
      degree  <= '0;
      done_id <= 1'b0;
`ifndef RS_DEGREE_FAST_EN
      idx     <= DEGW'(NCOEF - 1);
`endif
    end else begin
      if (grant_a || grant_b) begin
        coef_q <= grant_b ? poly_b : poly_a;
        tag    <= grant_b;
        last_b <= grant_b;
`ifndef RS_DEGREE_FAST_EN
        idx    <= DEGW'(NCOEF - 1);
`endif
      end
      if (state == SCAN && !clear) begin
        if (scan_end) begin
          degree  <= found_deg;
          done_id <= tag;
        end
`ifndef RS_DEGREE_FAST_EN
        else begin
          idx <= idx - 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_rs_degree_scheduler.sv
// tb/tb_rs_degree_scheduler.sv - directed table-driven bench for rs_degree_scheduler
module tb_rs_degree_scheduler;

  localparam int PW = 120;

  logic          CLK = 1'b0;
  logic          RESET = 1'b0;
  logic          clear = 1'b0;
  logic          req_a = 1'b0;
  logic          req_b = 1'b0;
  logic [PW-1:0] poly_a = '0;
  logic [PW-1:0] poly_b = '0;
  logic          grant_a, grant_b, busy, done, done_id;
  logic [4:0]    degree;

  int n_chk = 0;
  int n_fail = 0;

  rs_degree_scheduler dut (
    .CLK(CLK), .RESET(RESET), .clear(clear),
    .req_a(req_a), .poly_a(poly_a), .req_b(req_b), .poly_b(poly_b),
    .grant_a(grant_a), .grant_b(grant_b), .busy(busy), .done(done),
    .done_id(done_id), .degree(degree)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic          ra;
    logic          rb;
    logic [PW-1:0] pa;
    logic [PW-1:0] pb;
    logic          exp_b;
    int            exp_deg;
  } vec_t;

  vec_t vecs[7];

  function automatic logic [PW-1:0] mk(input int i, input logic [5:0] v);
    logic [PW-1:0] p;
    p = '0;
    p[i*6 +: 6] = v;
    return p;
  endfunction

  function automatic int lat(input int d);
`ifdef RS_DEGREE_FAST_EN
    return 2 + 0 * d;
`else
    return 21 - d;
`endif
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_req(input logic ra, input logic rb, input logic [PW-1:0] pa,
                           input logic [PW-1:0] pb, input logic exp_b);
    @(negedge CLK);
    req_a = ra; req_b = rb; poly_a = pa; poly_b = pb;
    #1;
    chk("grant_a", int'(grant_a), int'(!exp_b));
    chk("grant_b", int'(grant_b), int'(exp_b));
  endtask

  task automatic wait_done(input int exp_lat, input int exp_id, input int exp_deg);
    bit seen;
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge CLK);
      if (k == 1) begin req_a = 0; req_b = 0; end
      #1;
      if (grant_a && grant_b) chk("dual_grant", 1, 0);
      if (k == 1) chk("busy_in_scan", int'(busy), 1);
      if (done) begin
        seen = 1;
        chk("done_latency", k, exp_lat);
        chk("done_id", int'(done_id), exp_id);
        chk("degree", int'(degree), exp_deg);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int clr_k;
    bit seen;

    vecs[0] = '{1'b1, 1'b1, mk(3, 6'h01), mk(12, 6'h2A), 1'b0, 3};
    vecs[1] = '{1'b1, 1'b1, mk(3, 6'h01), mk(12, 6'h2A), 1'b1, 12};
    vecs[2] = '{1'b1, 1'b0, mk(7, 6'h15), '0, 1'b0, 7};
    vecs[3] = '{1'b0, 1'b1, '0, '0, 1'b1, 0};
    vecs[4] = '{1'b0, 1'b1, '0, mk(0, 6'h01), 1'b1, 0};
    vecs[5] = '{1'b0, 1'b1, '0, mk(19, 6'h3F), 1'b1, 19};
    vecs[6] = '{1'b1, 1'b0, mk(5, 6'h11) | mk(10, 6'h02), '0, 1'b0, 10};

    // Reset state, with both requests already high
    req_a = 1; req_b = 1;
    #1;
    chk("rst_grant_a", int'(grant_a), 0);
    chk("rst_grant_b", int'(grant_b), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_done_id", int'(done_id), 0);
    chk("rst_degree", int'(degree), 0);
    @(negedge CLK);
    req_a = 0; req_b = 0;
    #2 RESET = 1;

    foreach (vecs[i]) begin
      start_req(vecs[i].ra, vecs[i].rb, vecs[i].pa, vecs[i].pb, vecs[i].exp_b);
      wait_done(lat(vecs[i].exp_deg), int'(vecs[i].exp_b), vecs[i].exp_deg);
    end

    // B requests while A is scanning: no grant until after A's done
    start_req(1, 0, mk(7, 6'h15), '0, 0);
    seen = 0;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge CLK);
      if (k == 1) begin req_a = 0; req_b = 1; poly_b = mk(19, 6'h3F); end
      #1;
      if (grant_b) chk("grant_b_while_busy", 1, 0);
      if (done) begin
        seen = 1;
        chk("busy_a_latency", k, lat(7));
        chk("busy_a_degree", int'(degree), 7);
      end
    end
    if (!seen) chk("busy_a_timeout", 0, 1);
    @(negedge CLK); #1;
    chk("grant_b_after_done", int'(grant_b), 1);
    wait_done(lat(19), 1, 19);

    // clear mid-scan: no done, busy drops, degree unchanged
`ifdef RS_DEGREE_FAST_EN
    clr_k = 1;
`else
    clr_k = 5;
`endif
    start_req(1, 0, mk(2, 6'h09), '0, 0);
    for (int k = 1; k <= clr_k; k++) begin
      @(negedge CLK);
      if (k == 1) req_a = 0;
      #1;
      if (done) chk("done_before_clear", 1, 0);
    end
    clear = 1;
    @(negedge CLK); #1;
    chk("clear_busy", int'(busy), 0);
    chk("clear_done", int'(done), 0);
    chk("clear_degree", int'(degree), 19);
    clear = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge CLK); #1;
      if (done) chk("done_after_clear", 1, 0);
    end

    // clear with req_a in IDLE wins; grant follows once clear drops
    @(negedge CLK);
    clear = 1; req_a = 1; poly_a = mk(4, 6'h01);
    #1;
    chk("clear_blocks_grant", int'(grant_a), 0);
    @(negedge CLK); #1;
    chk("clear_idle_busy", int'(busy), 0);
    clear = 0;
    #1;
    chk("grant_after_clear", int'(grant_a), 1);
    wait_done(lat(4), 0, 4);

    // RESET mid-scan returns outputs to reset values
    start_req(0, 1, '0, mk(5, 6'h02), 1);
    wait_done(lat(5), 1, 5);
    start_req(1, 0, mk(1, 6'h07), '0, 0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge CLK);
      if (k == 1) req_a = 0;
    end
    #1;
    RESET = 0; req_a = 1; req_b = 1; poly_a = mk(1, 6'h07);
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_done", int'(done), 0);
    chk("mid_rst_degree", int'(degree), 0);
    chk("mid_rst_done_id", int'(done_id), 0);
    chk("mid_rst_grant_a", int'(grant_a), 0);
    chk("mid_rst_grant_b", int'(grant_b), 0);
    @(negedge CLK);
    RESET = 1;
    #1;
    chk("post_rst_grant_a", int'(grant_a), 1);
    chk("post_rst_grant_b", int'(grant_b), 0);
    wait_done(lat(1), 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
